// File: rtl/shift_pkg.sv
// Shared word width and shift-mode encoding for the serial deserialiser.
package shift_pkg;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        MODE_MSB    = 2'b00,
        MODE_HOLD   = 2'b01,
        MODE_LSB    = 2'b10,
        MODE_RESYNC = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shift_out_buf.sv
// Single-entry output buffer: holds a completed word until consumed and flags dropped words.
module shift_out_buf
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word_in,
    input  logic              resync,
    input  logic              data_ready,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              overrun
);

    logic              take_word;
    logic              drop_word;

    // A pop in the same cycle as a completion frees the slot for the new word.
    assign take_word = load && (!data_valid || data_ready);
    assign drop_word = load && data_valid && !data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (take_word) begin
                data_out   <= word_in;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            if (resync) begin
                overrun <= 1'b0;
            end else if (drop_word) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_deser8.sv
// Serial-to-parallel deserialiser with per-bit direction control and a one-word output buffer.
module shift_deser8
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              serial_in,
    input  logic [1:0]        shift_direction,
    input  logic              data_ready,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              overrun,
    output logic [CNT_W-1:0]  bit_count
);

    shift_mode_e       mode;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              shift_en;
    logic              resync;
    logic              complete;

    assign mode = shift_mode_e'(shift_direction);

    always_comb begin
        asm_d    = asm_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        resync   = 1'b0;
        if (enable) begin
            unique case (mode)
                MODE_MSB: begin
                    asm_d    = {asm_q[WORD_W-2:0], serial_in};
                    cnt_d    = cnt_q + CNT_W'(1);
                    shift_en = 1'b1;
                end
                MODE_LSB: begin
                    asm_d    = {serial_in, asm_q[WORD_W-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
                    shift_en = 1'b1;
                end
                MODE_RESYNC: begin
                    asm_d  = '0;
                    cnt_d  = '0;
                    resync = 1'b1;
                end
                MODE_HOLD: begin
                end
            endcase
        end
    end

    // The counter wraps naturally from 7 to 0 on the completing shift.
    assign complete  = shift_en && (cnt_q == '1);
    assign bit_count = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else begin
            asm_q <= asm_d;
            cnt_q <= cnt_d;
        end
    end

    shift_out_buf u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (complete),
        .word_in    (asm_d),
        .resync     (resync),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_shift_deser8.sv
// Self-checking bench for shift_deser8: vector table, directed corner sequences, random soak.
module tb_shift_deser8;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       serial_in;
    logic [1:0] shift_direction;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overrun;
    logic [2:0] bit_count;

    int total = 0;
    int bad   = 0;

    // Reference model: word built arithmetically, counter as plain integer.
    int m_asm = 0;
    int m_cnt = 0;
    int m_out = 0;
    int m_vld = 0;
    int m_ovr = 0;

    always #5 clk = ~clk;

    shift_deser8 dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .serial_in       (serial_in),
        .shift_direction (shift_direction),
        .data_ready      (data_ready),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .overrun         (overrun),
        .bit_count       (bit_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit en, input bit sin, input bit [1:0] dir, input bit rdy);
        bit done = 0;
        if (rst) begin
            m_asm = 0; m_cnt = 0; m_out = 0; m_vld = 0; m_ovr = 0;
        end else begin
            if (en && dir == 2'b00) begin
                m_asm = (m_asm * 2 + int'(sin)) % 256;
                m_cnt++;
            end else if (en && dir == 2'b10) begin
                m_asm = m_asm / 2 + int'(sin) * 128;
                m_cnt++;
            end
            if (m_cnt == 8) begin
                m_cnt = 0;
                done  = 1;
            end
            if (en && dir == 2'b11) begin
                m_asm = 0;
                m_cnt = 0;
            end
            if (done) begin
                if (m_vld == 0 || rdy) begin
                    m_out = m_asm;
                    m_vld = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (rdy && m_vld == 1) begin
                m_vld = 0;
            end
            if (en && dir == 2'b11) m_ovr = 0;
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit sin, input bit [1:0] dir, input bit rdy);
        reset           = rst;
        enable          = en;
        serial_in       = sin;
        shift_direction = dir;
        data_ready      = rdy;
        model_edge(rst, en, sin, dir, rdy);
        @(posedge clk);
        #1;
        chk("model data_out",   int'(data_out),   m_out);
        chk("model data_valid", int'(data_valid), m_vld);
        chk("model overrun",    int'(overrun),    m_ovr);
        chk("model bit_count",  int'(bit_count),  m_cnt);
    endtask

    // seq[7] is sent first; data_ready is raised only on the final bit when asked.
    task automatic send_word(input bit [1:0] dir, input bit [7:0] seq, input bit rdy_last);
        for (int i = 7; i >= 0; i--)
            step(0, 1, seq[i], dir, (i == 0) ? rdy_last : 1'b0);
    endtask

    task automatic pop();
        step(0, 0, 0, 2'b01, 1);
    endtask

    typedef struct {
        bit [1:0] dir;
        bit [7:0] seq;
        bit [7:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{2'b00, 8'hA5, 8'hA5};
        vecs[1] = '{2'b10, 8'hA5, 8'hA5};
        vecs[2] = '{2'b00, 8'h3C, 8'h3C};
        vecs[3] = '{2'b10, 8'h01, 8'h80};
        vecs[4] = '{2'b10, 8'hC8, 8'h13};
        vecs[5] = '{2'b00, 8'hFF, 8'hFF};

        // Reset state
        step(1, 0, 0, 2'b00, 0);
        step(1, 1, 1, 2'b00, 1);
        chk("reset data_out", int'(data_out), 0);
        chk("reset valid", int'(data_valid), 0);
        chk("reset overrun", int'(overrun), 0);
        chk("reset bit_count", int'(bit_count), 0);

        foreach (vecs[k]) begin
            pop();
            send_word(vecs[k].dir, vecs[k].seq, 0);
            chk("vec data_out", int'(data_out), int'(vecs[k].exp_out));
            chk("vec valid", int'(data_valid), 1);
            chk("vec bit_count", int'(bit_count), 0);
            chk("vec overrun", int'(overrun), 0);
        end

        // Backpressure and overrun, cleared by resync
        pop();
        send_word(2'b00, 8'h3C, 0);
        send_word(2'b00, 8'hFF, 0);
        chk("bp data_out", int'(data_out), 8'h3C);
        chk("bp overrun", int'(overrun), 1);
        chk("bp valid", int'(data_valid), 1);
        step(0, 1, 0, 2'b11, 0);
        chk("resync overrun", int'(overrun), 0);
        chk("resync keeps out", int'(data_out), 8'h3C);
        chk("resync keeps valid", int'(data_valid), 1);

        // Simultaneous pop and complete
        pop();
        send_word(2'b00, 8'h11, 0);
        send_word(2'b00, 8'h22, 1);
        chk("popcmp data_out", int'(data_out), 8'h22);
        chk("popcmp valid", int'(data_valid), 1);
        chk("popcmp overrun", int'(overrun), 0);

        // Resync then reset mid-word
        pop();
        step(0, 1, 1, 2'b00, 0);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 1, 2'b00, 0);
        chk("partial count", int'(bit_count), 3);
        step(0, 1, 0, 2'b11, 0);
        chk("resync count", int'(bit_count), 0);
        send_word(2'b00, 8'h5A, 0);
        chk("after resync out", int'(data_out), 8'h5A);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 2'b10, 0);
        chk("pre-reset count", int'(bit_count), 5);
        step(1, 1, 1, 2'b00, 1);
        chk("midreset out", int'(data_out), 0);
        chk("midreset valid", int'(data_valid), 0);
        chk("midreset count", int'(bit_count), 0);
        step(0, 1, 1, 2'b00, 0);
        chk("post-reset first bit", int'(bit_count), 1);
        step(1, 0, 0, 2'b00, 0);

        // Gaps and hold strobes must not disturb assembly
        for (int w = 0; w < 4; w++) begin
            bit [7:0] word = 8'($urandom);
            pop();
            for (int i = 7; i >= 0; i--) begin
                int gaps = int'($urandom_range(0, 3));
                for (int g = 0; g < gaps; g++) begin
                    if ($urandom_range(0, 1) == 1)
                        step(0, 1, 1'($urandom), 2'b01, 0);
                    else
                        step(0, 0, 1'($urandom), 2'($urandom), 0);
                end
                step(0, 1, word[i], 2'b00, 0);
            end
            chk("gapped data_out", int'(data_out), int'(word));
            chk("gapped valid", int'(data_valid), 1);
        end

        // Random soak against the model
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
